muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width (only 32 supported).
REQ-002 The block SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port op, input, 3, RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have port src1, input, 32, rs1 operand (dividend / multiplicand).
REQ-007 The block SHALL have port src2, input, 32, rs2 operand (divisor / multiplier).
REQ-008 The block SHALL have port flush, input, 1, abort the in-flight operation (pipeline kill).
REQ-009 The block SHALL have port ready, output, 1, block can accept start this cycle.
REQ-010 The block SHALL have port busy, output, 1, iteration in progress; pipeline stalls on it.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse: result valid.
REQ-012 The block SHALL have port result, output, 32, final result.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX, DONE; ready = (IDLE or DONE), busy = (CALC or FIX), done = DONE.
REQ-014 Accept = start && ready && !flush; src1, src2 and op SHALL be registered on accept; later input changes SHALL NOT affect the operation.
REQ-015 Normal path: accept -> CALC for exactly 32 cycles (6-bit iteration counter, 31 down to 0) -> FIX 1 cycle -> DONE 1 cycle; done SHALL assert on the 34th rising edge after the accept edge.
REQ-016 Multiply: radix-2 shift-add on operand magnitudes, 64-bit product; src1 signed for MULH/MULHSU; src2 signed for MULH only; FIX negates the product when the signs of the signed operands differ.
REQ-017 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-018 Divide: radix-2 restoring division on magnitudes (signed for DIV/REM); FIX negates the quotient if the operand signs differ and the remainder if the dividend is negative.
REQ-019 Divide by zero (src2 == 0, all divide ops) SHALL bypass CALC: IDLE/DONE -> DONE directly; DIV/DIVU result 0xFFFFFFFF; REM/REMU result = src1.
REQ-020 Signed overflow (DIV/REM, src1 = 0x80000000, src2 = 0xFFFFFFFF) SHALL bypass CALC: DIV result 0x80000000, REM result 0.
REQ-021 Bypass latency: done SHALL assert on the 1st edge after accept.
REQ-022 DONE -> CALC (or DONE, on bypass) if accept occurs in DONE; otherwise DONE -> IDLE; back-to-back operations SHALL incur no idle cycle.
REQ-023 result SHALL update only on entry to DONE and SHALL hold until the next DONE entry (stable through IDLE).
REQ-024 flush SHALL be synchronous: next state = IDLE from any state; no done pulse for the aborted operation; result unchanged.
REQ-025 flush and start asserted together: flush wins, start ignored.
REQ-026 start while busy SHALL be ignored (no queuing).

Reset
REQ-027 While rst_n = 0 the block SHALL be in IDLE: ready = 1, busy = 0, done = 0, result = 0, counter = 0, operand/working registers = 0.
REQ-028 Reset assertion mid-operation SHALL abort immediately (asynchronous) with no done pulse; the first accept after rst_n deassertion SHALL behave as from power-up.

Verification
REQ-029 MUL src1 = 7, src2 = 0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done exactly 34 edges after accept, busy high for 33 cycles.
REQ-030 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-031 DIVU 100/7 -> 14 and REMU 100/7 -> 2; DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF; issue the second op in the DONE cycle of the first -> accepted with no gap.
REQ-032 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; each done 1 edge after accept, busy never high.
REQ-033 DIVU 1000/3 started, flush pulsed 10 cycles later -> IDLE next edge, no done, result keeps prior value; start+flush same cycle -> not accepted.
REQ-034 rst_n driven low asynchronously mid-CALC -> outputs at reset values before the next clk edge; no done pulse; a subsequent MUL 3 x 4 -> 12.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, then a
// single sign-fixup cycle. Divide-by-zero and signed overflow finish immediately.
`timescale 1ns/1ps

module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, next_state;
    logic [5:0]         count;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q, rem_neg_q;

    logic               accept, bypass;
    logic               s1_signed, s2_signed, sign1, sign2, div_zero, div_ovf;
    logic [WIDTH-1:0]   mag1, mag2, bypass_val, fix_val, quo, rem;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;

    assign ready  = (state == IDLE) || (state == DONE);
    assign busy   = (state == CALC) || (state == FIX);
    assign done   = (state == DONE);
    assign accept = start && ready && !flush;

    // Operand decode: signedness per funct3, magnitudes, and the two early-out cases.
    always_comb begin
        s1_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        s2_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sign1     = s1_signed && src1[WIDTH-1];
        sign2     = s2_signed && src2[WIDTH-1];
        mag1      = sign1 ? -src1 : src1;
        mag2      = sign2 ? -src2 : src2;
        div_zero  = op[2] && (src2 == '0);
        div_ovf   = op[2] && !op[0] && (src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (src2 == '1);
        bypass    = div_zero || div_ovf;
        if (div_zero) begin
            bypass_val = op[1] ? src1 : '1;
        end else begin
            bypass_val = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    // One shift-add or restore step, plus the final sign correction.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_q : '0)};
        mul_step  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (div_diff[WIDTH]) begin
            div_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (op_q[2]) begin
            fix_val = op_q[1] ? rem : quo;
        end else begin
            fix_val = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    next_state = bypass ? DONE : CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            CALC:    if (count == 6'd0) next_state = FIX;
            FIX:     next_state = DONE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    // Multiply keeps the multiplier in acc's low half; divide keeps the dividend there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            op_q      <= '0;
            b_q       <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q      <= op;
                neg_q     <= sign1 ^ sign2;
                rem_neg_q <= sign1;
                count     <= 6'(WIDTH-1);
                if (op[2]) begin
                    acc <= {{WIDTH{1'b0}}, mag1};
                    b_q <= mag2;
                end else begin
                    acc <= {{WIDTH{1'b0}}, mag2};
                    b_q <= mag1;
                end
                if (bypass) begin
                    result <= bypass_val;
                end
            end else if (state == CALC && !flush) begin
                acc   <= op_q[2] ? div_step : mul_step;
                count <= count - 6'd1;
            end else if (state == FIX && !flush) begin
                result <= fix_val;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: a vector table plus hand-written
// sequences for back-to-back issue, flush, start-while-busy and async reset.
`timescale 1ns/1ps

module tb_muldiv_seq;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
        bit          isBypass;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        ready, busy, done;
    logic [31:0] result;

    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] lastResult = '0;
    vec_t        vecs[18];

    muldiv_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .flush  (flush),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called #1 after an accept edge; latency counts the accept edge as edge 1.
    task automatic waitDone(input int lat0, output int lat, output int busyCnt, output bit seen);
        lat = lat0;
        busyCnt = 0;
        seen = 1'b0;
        while (!seen && lat <= 120) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busyCnt++;
                @(posedge clk);
                #1;
                lat++;
            end
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        src1  = $urandom;
        src2  = $urandom;
    endtask

    task automatic applyStimulus(input vec_t v);
        int lat, busyCnt;
        bit seen;
        issue(v.op, v.a, v.b);
        waitDone(1, lat, busyCnt, seen);
        checkOutput({v.name, "_done_seen"}, 32'(seen), 32'd1);
        checkOutput({v.name, "_latency"}, 32'(lat), v.isBypass ? 32'd1 : 32'd34);
        checkOutput({v.name, "_busy_cycles"}, 32'(busyCnt), v.isBypass ? 32'd0 : 32'd33);
        checkOutput({v.name, "_result"}, result, v.expResult);
        @(posedge clk);
        #1;
        checkOutput({v.name, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({v.name, "_result_hold"}, result, v.expResult);
        lastResult = v.expResult;
    endtask

    task automatic runBackToBack(input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                                 input logic [31:0] e1, input logic [2:0] o2, input logic [31:0] a2,
                                 input logic [31:0] b2, input logic [31:0] e2, input bit byp, input string name);
        int lat, busyCnt;
        bit seen;
        issue(o1, a1, b1);
        waitDone(1, lat, busyCnt, seen);
        checkOutput({name, "_first_latency"}, 32'(lat), byp ? 32'd1 : 32'd34);
        checkOutput({name, "_first_result"}, result, e1);
        start = 1'b1;
        op    = o2;
        src1  = a2;
        src2  = b2;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!byp) begin
            checkOutput({name, "_nogap_busy"}, 32'(busy), 32'd1);
        end
        waitDone(1, lat, busyCnt, seen);
        checkOutput({name, "_second_latency"}, 32'(lat), byp ? 32'd1 : 32'd34);
        checkOutput({name, "_second_result"}, result, e2);
        @(posedge clk);
        #1;
        checkOutput({name, "_second_pulse"}, 32'(done), 32'd0);
        lastResult = e2;
    endtask

    initial begin
        int lat, busyCnt, doneHits;
        bit seen;

        vecs[0]  = '{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_7xm3"};
        vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "mulh_min"};
        vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_max"};
        vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, "mulhsu_m1x2"};
        vecs[4]  = '{3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, "mul_wrap"};
        vecs[5]  = '{3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0, "mulhu_2p32"};
        vecs[6]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, "mulh_m1xm1"};
        vecs[7]  = '{3'b101, 32'd100,       32'd7,        32'd14,       1'b0, "divu_100_7"};
        vecs[8]  = '{3'b100, 32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0, "div_20_m3"};
        vecs[9]  = '{3'b110, 32'd20,        32'hFFFFFFFD, 32'd2,        1'b0, "rem_20_m3"};
        vecs[10] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, "divu_max_1"};
        vecs[11] = '{3'b111, 32'hFFFFFFFF, 32'd10,       32'd5,        1'b0, "remu_max_10"};
        vecs[12] = '{3'b100, 32'd5,         32'd0,        32'hFFFFFFFF, 1'b1, "div_by0"};
        vecs[13] = '{3'b110, 32'd5,         32'd0,        32'd5,        1'b1, "rem_by0"};
        vecs[14] = '{3'b101, 32'd5,         32'd0,        32'hFFFFFFFF, 1'b1, "divu_by0"};
        vecs[15] = '{3'b111, 32'h12345678, 32'd0,        32'h12345678, 1'b1, "remu_by0"};
        vecs[16] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf"};
        vecs[17] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "rem_ovf"};

        #3;
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
        end

        runBackToBack(3'b101, 32'd100, 32'd7, 32'd14, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, "b2b_divu_remu");
        runBackToBack(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, "b2b_div_rem");
        runBackToBack(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 3'b110, 32'd5, 32'd0, 32'd5, 1'b1, "b2b_bypass");

        // A start pulse mid-operation must neither queue nor disturb the running multiply.
        issue(3'b000, 32'h00001234, 32'h00000010);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = 3'b101;
        src1  = 32'd9;
        src2  = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(7, lat, busyCnt, seen);
        checkOutput("busy_start_latency", 32'(lat), 32'd34);
        checkOutput("busy_start_result", result, 32'h00012340);
        @(posedge clk);
        #1;
        checkOutput("busy_start_no_requeue", 32'(done), 32'd0);
        lastResult = 32'h00012340;

        // Flush mid-calculation: back to idle at once, no done, result untouched.
        issue(3'b101, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_ready", 32'(ready), 32'd1);
        checkOutput("flush_done", 32'(done), 32'd0);
        doneHits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) doneHits++;
        end
        checkOutput("flush_no_done", 32'(doneHits), 32'd0);
        checkOutput("flush_result_kept", result, lastResult);

        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 3'b101;
        src1  = 32'd1000;
        src2  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checkOutput("start_flush_busy", 32'(busy), 32'd0);
        checkOutput("start_flush_done", 32'(done), 32'd0);
        doneHits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) doneHits++;
        end
        checkOutput("start_flush_no_done", 32'(doneHits), 32'd0);

        // Asynchronous reset mid-CALC must clear outputs before the next clock edge.
        issue(3'b000, 32'd5, 32'd6);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_ready", 32'(ready), 32'd1);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        checkOutput("async_reset_done", 32'(done), 32'd0);
        checkOutput("async_reset_result", result, 32'd0);
        doneHits = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) doneHits++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) doneHits++;
        end
        checkOutput("async_reset_no_done", 32'(doneHits), 32'd0);
        applyStimulus('{3'b000, 32'd3, 32'd4, 32'd12, 1'b0, "mul_after_reset"});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
